muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit that sits beside the single-cycle ALU in the EX stage.
//  It executes mult/multu/div/divu over 32 iterations and owns the HI/LO registers.
//  The ALU takes one cycle and has no handshake. This block accepts an operation with

---
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and HI/LO bus between the EX stage and the iterative multiply/divide unit.
// The pipeline drives through master; the unit connects through slave.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, A, B, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, A, B, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu unit owning HI/LO.
// Fixed 33-cycle latency: 32 shift-add or restoring shift-subtract steps, then a done cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opb_r;
  logic [WIDTH-1:0]   a_orig_r;
  logic               is_div_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic               divzero_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               accept_s;
  logic               last_s;
  logic               busy_s;
  logic               done_s;
  logic               sa_s;
  logic               sb_s;
  logic [WIDTH-1:0]   amag_s;
  logic [WIDTH-1:0]   bmag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH+1:0]   div_diff_s;
  logic [2*WIDTH-1:0] step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  assign accept_s = (state_r == IDLE) && bus.start;
  assign last_s   = (state_r == RUN) && (cnt_r == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = bus.start ? RUN : IDLE;
      RUN:     state_s = last_s ? FIN : RUN;
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Status outputs decoded from state; FIN still counts as busy.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      IDLE:    begin busy_s = 1'b0; done_s = 1'b0; end
      RUN:     begin busy_s = 1'b1; done_s = 1'b0; end
      FIN:     begin busy_s = 1'b1; done_s = 1'b1; end
      default: begin busy_s = 1'b0; done_s = 1'b0; end
    endcase
  end

  // Sign flags and magnitudes taken at accept; unsigned ops never see a sign.
  always_comb begin
    sa_s   = ~bus.op[0] & bus.A[WIDTH-1];
    sb_s   = ~bus.op[0] & bus.B[WIDTH-1];
    amag_s = cond_neg(bus.A, sa_s);
    bmag_s = cond_neg(bus.B, sb_s);
  end

  // One iteration. acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, (acc_r[0] ? opb_r : {WIDTH{1'b0}})};
    div_diff_s = {1'b0, acc_r[2*WIDTH-1:WIDTH-1]} - {2'b00, opb_r};
    if (is_div_r) begin
      if (!div_diff_s[WIDTH+1]) begin
        step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        step_s = {acc_r[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the final step; divide by zero returns all-ones / original dividend.
  always_comb begin
    prod_s   = neg_q_r ? ({(2*WIDTH){1'b0}} - step_s) : step_s;
    res_hi_s = prod_s[2*WIDTH-1:WIDTH];
    res_lo_s = prod_s[WIDTH-1:0];
    if (!is_div_r) begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end else if (divzero_r) begin
      res_hi_s = a_orig_r;
      res_lo_s = {WIDTH{1'b1}};
    end else begin
      res_hi_s = cond_neg(step_s[2*WIDTH-1:WIDTH], neg_r_r);
      res_lo_s = cond_neg(step_s[WIDTH-1:0], neg_q_r);
    end
  end

  // Operand latch, iteration datapath and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      opb_r     <= {WIDTH{1'b0}};
      a_orig_r  <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      divzero_r <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        cnt_r     <= {CW{1'b0}};
        is_div_r  <= bus.op[1];
        neg_q_r   <= sa_s ^ sb_s;
        neg_r_r   <= sa_s;
        a_orig_r  <= bus.A;
        divzero_r <= (bus.B == {WIDTH{1'b0}});
        if (bus.op[1]) begin
          acc_r <= {{WIDTH{1'b0}}, amag_s};
          opb_r <= bmag_s;
        end else begin
          acc_r <= {{WIDTH{1'b0}}, bmag_s};
          opb_r <= amag_s;
        end
      end else if (state_r == RUN) begin
        acc_r <= step_s;
        cnt_r <= cnt_r + CW'(1'b1);
      end
      // A write coinciding with accept lands now and is overwritten by the result later.
      if (last_s) begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
      end else if (state_r == IDLE) begin
        if (bus.hi_we) hi_r <= bus.wdata;
        if (bus.lo_we) lo_r <= bus.wdata;
      end
    end
  end

  assign bus.busy = busy_s;
  assign bus.done = done_s;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latency, busy/done timing,
// ignored start/mthi while busy, mid-operation reset and idle HI/LO writes.
module tb_muldiv_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: plain run; 1: inject start at T+5 and mthi at T+10; 2: reset at T+20
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int mode);
    int n;
    int done_cyc;
    int done_cnt;
    @(negedge clk);
    check_eq({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    n        = 0;
    done_cyc = 0;
    done_cnt = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = n;
          check_eq({tag, "_hi"}, bus.hi, ehi);
          check_eq({tag, "_lo"}, bus.lo, elo);
          check_eq({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd1);
        end
      end
      if (n == 1) begin
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        bus.op    = ~o;
        check_eq({tag, "_busy_t1"}, {31'd0, bus.busy}, 32'd1);
      end
      if (mode == 1 && n == 5) begin
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.A     = 32'h0000_0011;
        bus.B     = 32'h0000_0003;
      end
      if (mode == 1 && n == 6) bus.start = 1'b0;
      if (mode == 1 && n == 10) begin
        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
      end
      if (mode == 1 && n == 11) bus.hi_we = 1'b0;
      if (mode == 2 && n == 20) reset = 1'b1;
      if (mode == 2 && n == 21) begin
        reset = 1'b0;
        check_eq({tag, "_rst_busy"}, {31'd0, bus.busy}, 32'd0);
        check_eq({tag, "_rst_done"}, {31'd0, bus.done}, 32'd0);
        check_eq({tag, "_rst_hi"}, bus.hi, 32'd0);
        check_eq({tag, "_rst_lo"}, bus.lo, 32'd0);
      end
      if (mode != 2 && n == 34) check_eq({tag, "_busy_t34"}, {31'd0, bus.busy}, 32'd0);
    end
    if (mode == 2) begin
      check_eq({tag, "_no_done"}, done_cnt, 32'd0);
    end else begin
      check_eq({tag, "_latency"}, done_cyc, 32'd33);
      check_eq({tag, "_done_pulses"}, done_cnt, 32'd1);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("reset_done", {31'd0, bus.done}, 32'd0);
    check_eq("reset_hi", bus.hi, 32'd0);
    check_eq("reset_lo", bus.lo, 32'd0);
    reset = 1'b0;

    // Idle mthi+mtlo together, then mtlo alone.
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    check_eq("mt_both_hi", bus.hi, 32'hA5A5_A5A5);
    check_eq("mt_both_lo", bus.lo, 32'hA5A5_A5A5);
    @(negedge clk);
    bus.lo_we = 1'b0;
    check_eq("mtlo_hi", bus.hi, 32'hA5A5_A5A5);
    check_eq("mtlo_lo", bus.lo, 32'h0000_1234);

    run_op("mult_7_m3",   2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op("multu_ff",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult_ff",     2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0);
    run_op("div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_7_m2",    2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    run_op("divu_100_7",  2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        0);
    run_op("divu_by0",    2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 0);
    run_op("div_m5_by0",  2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
    run_op("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    run_op("busy_inject", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1);
    run_op("mid_reset",   2'b00, 32'd5,         32'd6,         32'd0,         32'd30,        2);
    run_op("after_reset", 2'b01, 32'd6,         32'd7,         32'd0,         32'd42,        0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
